// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the KGP-RISC fetch stage.
// Holds the fetch address and hands it to instruction memory with a
// req/ack handshake. It supports sequential, absolute, PC-relative,
// register-indirect, call and return redirects, and keeps return
// addresses on a circular RAS. A redirect that arrives while no advance
// is possible is held in a pending register until the next advance.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one cycle after reset release, no fetch request yet
// FETCH | fetch_req high, pc held until an accepted, unstalled fetch

module pc_sequencer #(
  parameter int              PC_W      = 32,
  parameter int              OFFSET_W  = 26,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                fetch_ack,
  input  logic                redirect_valid,
  input  logic [2:0]          redirect_mode,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [PC_W-1:0]     target_reg,
  output logic [PC_W-1:0]     pc,
  output logic                fetch_req,
  output logic                ras_ovf,
  output logic                ras_unf,
  output logic                illegal_mode
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  // Wide enough for both the shifted offset and the pc, so ABS/REL can be
  // built first and then truncated to PC_W.
  localparam int EXT_W = (PC_W > OFFSET_W + 2) ? PC_W : OFFSET_W + 2;

  localparam logic [2:0] MODE_ABS  = 3'd0;
  localparam logic [2:0] MODE_REL  = 3'd1;
  localparam logic [2:0] MODE_REG  = 3'd2;
  localparam logic [2:0] MODE_CALL = 3'd3;
  localparam logic [2:0] MODE_RET  = 3'd4;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              adv;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_nxt;
  logic [EXT_W-1:0]  abs_ext;
  logic [EXT_W-1:0]  rel_ext;
  logic [PC_W-1:0]   abs_tgt;
  logic [PC_W-1:0]   rel_tgt;
  logic [PC_W-1:0]   reg_tgt;
  logic [PC_W-1:0]   rd_target;
  logic              rd_legal;
  logic              rd_illegal;

  logic              pend_valid;
  logic [PC_W-1:0]   pend_target;

  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_full;
  logic              ras_empty;
  logic              do_push;
  logic              do_pop;
  logic              ret_on_empty;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // FSM next state and fetch request
  always_comb begin
    state_nxt = state;
    fetch_req = 1'b0;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   fetch_req = 1'b1;
      default: state_nxt = BOOT;
    endcase
  end

  assign adv       = fetch_req & fetch_ack & ~stall;
  assign pc_inc    = pc + PC_W'(4);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_cnt == '0);

  // Offset-derived targets: zero-extended for ABS/CALL, sign-extended for REL
  always_comb begin
    abs_ext                 = '0;
    abs_ext[OFFSET_W+1:0]   = {offset, 2'b00};
    rel_ext                 = {EXT_W{offset[OFFSET_W-1]}};
    rel_ext[OFFSET_W+1:0]   = {offset, 2'b00};
  end

  assign abs_tgt = abs_ext[PC_W-1:0];
  assign rel_tgt = pc + rel_ext[PC_W-1:0];
  assign reg_tgt = target_reg & ~PC_W'(3);

  // Decode the redirect arriving this cycle and its RAS side effect
  always_comb begin
    rd_target    = pc_inc;
    rd_legal     = 1'b0;
    rd_illegal   = 1'b0;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    ret_on_empty = 1'b0;
    if (redirect_valid) begin
      rd_legal = 1'b1;
      case (redirect_mode)
        MODE_ABS: rd_target = abs_tgt;
        MODE_REL: rd_target = rel_tgt;
        MODE_REG: rd_target = reg_tgt;
        MODE_CALL: begin
          rd_target = abs_tgt;
          do_push   = 1'b1;
        end
        MODE_RET: begin
          if (ras_empty) begin
            rd_target    = pc_inc;
            ret_on_empty = 1'b1;
          end else begin
            rd_target = ras_mem[ras_top];
            do_pop    = 1'b1;
          end
        end
        default: begin
          rd_legal   = 1'b0;
          rd_illegal = 1'b1;
        end
      endcase
    end
  end

  // Next fetch address: live redirect, then pending redirect, then pc+4
  always_comb begin
    if (rd_legal)        pc_nxt = rd_target;
    else if (pend_valid) pc_nxt = pend_target;
    else                 pc_nxt = pc_inc;
  end

  // pc advances only on an accepted fetch; otherwise a redirect is parked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (adv) begin
      pc          <= pc_nxt;
      pend_valid  <= 1'b0;
    end else if (rd_legal) begin
      pend_valid  <= 1'b1;
      pend_target <= rd_target;
    end
  end

  // Return-address stack: a push when full overwrites the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_top <= '1;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (do_push) begin
      ras_top          <= ras_top + PTR_W'(1);
      ras_mem[ras_top + PTR_W'(1)] <= pc_inc;
      if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (do_pop) begin
      ras_top <= ras_top - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ovf      <= 1'b0;
      ras_unf      <= 1'b0;
      illegal_mode <= 1'b0;
    end else begin
      if (do_push && ras_full) ras_ovf      <= 1'b1;
      if (ret_on_empty)        ras_unf      <= 1'b1;
      if (rd_illegal)          illegal_mode <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: every accepted fetch must present the
// address queued by the stimulus; flags and stall/reset behaviour are
// checked directly against hand-computed values.

module tb_pc_sequencer;

  localparam logic [2:0] M_ABS  = 3'd0;
  localparam logic [2:0] M_REL  = 3'd1;
  localparam logic [2:0] M_REG  = 3'd2;
  localparam logic [2:0] M_CALL = 3'd3;
  localparam logic [2:0] M_RET  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [2:0]  redirect_mode = 3'd0;
  logic [25:0] offset = '0;
  logic [31:0] target_reg = '0;
  logic [31:0] pc;
  logic        fetch_req;
  logic        ras_ovf;
  logic        ras_unf;
  logic        illegal_mode;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ret_exp[4];
  logic [31:0] cur;

  pc_sequencer #(
    .PC_W(32), .OFFSET_W(26), .RAS_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ack(fetch_ack),
    .redirect_valid(redirect_valid), .redirect_mode(redirect_mode),
    .offset(offset), .target_reg(target_reg), .pc(pc),
    .fetch_req(fetch_req), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .illegal_mode(illegal_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus; optionally queue the pc expected on this fetch.
  task automatic step(input logic ack, input logic stl, input logic rv,
                      input logic [2:0] mode, input logic [25:0] off,
                      input logic [31:0] treg, input logic push,
                      input logic [31:0] exp);
    fetch_ack      = ack;
    stall          = stl;
    redirect_valid = rv;
    redirect_mode  = mode;
    offset         = off;
    target_reg     = treg;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted, unstalled fetch consumes one expected address.
  always @(negedge clk) begin
    if (rst_n && fetch_req && fetch_ack && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fetch: got pc 0x%08h expected no fetch", pc);
      end else begin
        check("fetch_pc", pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h50;
    ret_exp[2] = 32'h4C; ret_exp[3] = 32'h48;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, fetch_req}, 32'h0);
    check("rst_flags", {29'b0, ras_ovf, ras_unf, illegal_mode}, 32'h0);
    rst_n = 1'b1;

    // BOOT cycle, then sequential fetches 0,4,8,12
    check("boot_req", {31'b0, fetch_req}, 32'h0);
    step(1, 0, 0, M_ABS, 0, 0, 0, 0);
    check("fetch_req_high", {31'b0, fetch_req}, 32'h1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, M_ABS, 0, 0, 1, 32'(4 * i));

    // ABS to 0x100, then stall with ack high
    step(1, 0, 1, M_ABS, 26'h40, 0, 1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, M_ABS, 0, 0, 0, 0);
      check("stall_hold", pc, 32'h100);
    end
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'h100);
    check("after_stall", pc, 32'h104);
    step(1, 0, 1, M_ABS, 26'h80, 0, 1, 32'h104);

    // REL -4 pending while ack low
    step(0, 0, 1, M_REL, 26'h3FFFFFF, 0, 0, 0);
    check("rel_pending_hold", pc, 32'h200);
    step(0, 0, 0, M_ABS, 0, 0, 0, 0);
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'h200);
    check("rel_applied", pc, 32'h1FC);
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'h1FC);
    check("rel_seq", pc, 32'h200);

    // five CALLs from 0x40,0x44,..,0x50 (pushing 0x44..0x54)
    step(1, 0, 1, M_ABS, 26'h10, 0, 1, 32'h200);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < i; j++) step(1, 0, 0, M_ABS, 0, 0, 1, 32'(32'h40 + 4 * j));
      if (i == 4) check("ovf_before_5th", {31'b0, ras_ovf}, 32'h0);
      step(1, 0, 1, M_CALL, 26'h10, 0, 1, 32'(32'h40 + 4 * i));
    end
    check("ras_ovf", {31'b0, ras_ovf}, 32'h1);
    check("call_pc", pc, 32'h40);

    // four RETs in LIFO order, then one on an empty stack
    cur = 32'h40;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, M_RET, 0, 0, 1, cur);
      cur = ret_exp[k];
      check("ret_pc", pc, cur);
    end
    check("unf_before", {31'b0, ras_unf}, 32'h0);
    step(1, 0, 1, M_RET, 0, 0, 1, 32'h48);
    check("ret_empty_pc", pc, 32'h4C);
    check("ras_unf", {31'b0, ras_unf}, 32'h1);

    // ABS max offset, REG alignment, illegal mode
    step(1, 0, 1, M_ABS, 26'h3FFFFFF, 0, 1, 32'h4C);
    step(1, 0, 1, M_REG, 0, 32'h1003, 1, 32'h0FFFFFFC);
    check("ill_before", {31'b0, illegal_mode}, 32'h0);
    step(1, 0, 1, 3'd6, 26'h55, 0, 1, 32'h1000);
    check("ill_pc", pc, 32'h1004);
    check("illegal_mode", {31'b0, illegal_mode}, 32'h1);

    // wrap-around
    step(1, 0, 1, M_REG, 0, 32'hFFFFFFFF, 1, 32'h1004);
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'hFFFFFFFC);
    check("wrap_pc", pc, 32'h0);
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'h0);

    // redirect accepted during stall, applied on next advance
    step(1, 1, 1, M_ABS, 26'h20, 0, 0, 0);
    check("stall_redir_hold", pc, 32'h4);
    step(1, 0, 0, M_ABS, 0, 0, 1, 32'h4);
    check("stall_redir_pc", pc, 32'h80);

    // reset while a REL redirect is pending
    step(0, 0, 1, M_REL, 26'h10, 0, 0, 0);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst2_pc", pc, 32'h0);
    check("rst2_req", {31'b0, fetch_req}, 32'h0);
    check("rst2_flags", {29'b0, ras_ovf, ras_unf, illegal_mode}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("boot2_req", {31'b0, fetch_req}, 32'h0);
    step(1, 0, 0, M_ABS, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, M_ABS, 0, 0, 1, 32'(4 * i));
    check("post_rst_pc", pc, 32'hC);

    fetch_ack = 1'b0;
    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the KGP-RISC instruction-fetch stage; next generation of the single-mode PC update unit.
- Supports sequential, absolute, PC-relative, register-indirect, call and return redirects.
- Uses a depth-parametrised return-address stack (RAS).
- Adds a req/ack handshake to instruction memory, a stall input, and a pending-redirect register so no redirect is lost while a fetch is outstanding.

Parameters:
PC_W, 32, width of pc and all target arithmetic
OFFSET_W, 26, width of the instruction offset field
RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2)
RESET_PC, 0, pc value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  1 = hold pc, no advance
fetch_ack  in  1  instruction memory accepted/returned the word at pc
redirect_valid  in  1  redirect request this cycle
redirect_mode  in  3  0 ABS, 1 REL, 2 REG, 3 CALL, 4 RET, 5-7 illegal
offset  in  OFFSET_W  offset field of the branching instruction
target_reg  in  PC_W  register operand for REG mode
pc  out  PC_W  current fetch address
fetch_req  out  1  fetch request to instruction memory
ras_ovf  out  1  sticky: push onto full RAS
ras_unf  out  1  sticky: pop from empty RAS
illegal_mode  out  1  sticky: redirect with mode 5-7

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC, fetch_req=0, ras_ovf=ras_unf=illegal_mode=0.
- RAS count=0; pending redirect cleared; FSM=BOOT.
- Reset asserted mid-operation discards any outstanding fetch and pending redirect immediately.

FSM:
- BOOT: fetch_req=0 for exactly one clk after rst_n deasserts, then FETCH. Redirects in BOOT are accepted into pending.
- FETCH: fetch_req=1, pc held stable until advance. No other states.

Advance:
- adv = fetch_req & fetch_ack & ~stall. pc changes only on a clock edge with adv=1.
- fetch_ack while stall=1 is ignored; the same pc is re-requested.

Next pc on adv, in priority order:
1. redirect_valid this cycle: target computed this cycle.
2. Pending redirect valid: pending target; pending cleared.
3. Otherwise: pc+4.

Redirect acceptance:
- Accepted every cycle redirect_valid=1, including BOOT and stall.
- If not adv, the target is latched into the pending register.
- A second redirect before the pending one is consumed overwrites it (last wins). RAS side effects of the overwritten redirect are not undone.

Target computation (uses the pc value at acceptance; all sums mod 2^PC_W):
- ABS: zero-extend(offset<<2) to PC_W, i.e. {zeros, offset, 2'b00}, truncated if PC_W < OFFSET_W+2.
- REL: pc + sign-extend(offset<<2).
- REG: target_reg with bits [1:0] forced to 0.
- CALL: ABS target; push pc+4 onto RAS.
- RET: pop RAS top; if RAS empty, target=pc+4 and set ras_unf.
- Modes 5-7: treated as no redirect (pending unchanged); set illegal_mode.

RAS:
- Circular buffer with top pointer and count (0..RAS_DEPTH).
- Push when full overwrites the oldest entry, count stays RAS_DEPTH, sets ras_ovf.
- One push or one pop per cycle.

Wrap-around: pc+4 from 2^PC_W-4 wraps to 0, with no flag.

Sticky flags clear only on reset.

Test Plan:
- Reset release, fetch_ack=1 every cycle, no redirects -> fetch_req=0 for 1 cycle, then pc = 0, 4, 8, 12 on successive edges.
- pc=0x100, stall=1 for 3 cycles with fetch_ack=1 -> pc stays 0x100; first edge after stall drops -> 0x104.
- pc=0x200, REL redirect offset=-4 (all ones) with fetch_ack=0; fetch_ack asserted 2 cycles later -> pc=0x1FC on that edge; following advance -> 0x200.
- RAS_DEPTH=4: five CALLs (offset 0x10) from pc=0x40 region, then five RETs -> first four RETs return the last four pushed pc+4 values (LIFO), ras_ovf=1; fifth RET -> pc+4 with ras_unf=1.
- ABS offset=0x3FFFFFF with PC_W=32 -> pc=0x0FFFFFFC; REG target_reg=0x1003 -> pc=0x1000; mode 6 -> sequential pc+4 and illegal_mode=1.
- rst_n pulsed low while a REL redirect is pending and fetch_req=1 -> pc=RESET_PC immediately, pending dropped, BOOT cycle repeated, no redirect applied afterwards.
